// File: rtl/packet_serializer_if.sv
// Packet stream bundle for the 64-bit to 32-bit serializer: 64-bit word input side,
// 32-bit beat output side and the CPU error pulse.
`timescale 1ns/1ps
interface packet_serializer_if;
    logic        ivalid;
    logic        isop;
    logic        ieop;
    logic [63:0] idata;
    logic [2:0]  iresidual;
    logic        ibad;
    logic        iready;

    logic        ovalid;
    logic        osop;
    logic        oeop;
    logic [31:0] odata;
    logic [1:0]  oresidual;
    logic        obad;
    logic [13:0] oplen;
    logic        oready;
    logic        ocpu_interrupt;

    modport slave (
        input  ivalid, isop, ieop, idata, iresidual, ibad, oready,
        output iready, ovalid, osop, oeop, odata, oresidual, obad, oplen, ocpu_interrupt
    );

    modport master (
        output ivalid, isop, ieop, idata, iresidual, ibad, oready,
        input  iready, ovalid, osop, oeop, odata, oresidual, obad, oplen, ocpu_interrupt
    );
endinterface

// File: rtl/packet_serializer.sv
// Splits 64-bit packet words into 32-bit beats, counts packet bytes, and flags
// length and framing errors to the CPU.
`timescale 1ns/1ps
module packet_serializer #(
    parameter int MAX_PLEN = 9216,
    parameter int MIN_PLEN = 64
) (
    input  logic iclk,
    input  logic irst,
    packet_serializer_if.slave bus
);

    localparam logic [13:0] MAX_L = 14'(MAX_PLEN);
    localparam logic [13:0] MIN_L = 14'(MIN_PLEN);

    logic        ovalid_p0;
    logic        osop_p0;
    logic        oeop_p0;
    logic [31:0] odata_p0;
    logic [1:0]  ores_p0;
    logic        obad_p0;
    logic [13:0] oplen_p0;
    logic        irq_p0;

    logic        pend_vld;
    logic [31:0] pend_data;
    logic        pend_eop;
    logic [2:0]  pend_bytes;
    logic        pend_bad;

    logic        in_pkt;
    logic [13:0] count;

    function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [2:0] b);
        logic [14:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[14] ? 14'h3fff : s[13:0];
    endfunction

    function automatic logic len_bad(input logic [13:0] len);
        return (len > MAX_L) || (len < MIN_L);
    endfunction

    logic        free;
    logic        xfer;
    logic        ready;
    logic        accept;
    logic        stray;
    logic        restart;
    logic        single;
    logic [2:0]  hi_bytes;
    logic [2:0]  lo_bytes;
    logic [13:0] hi_count;
    logic [13:0] lo_count;

    assign free     = !ovalid_p0 || bus.oready;
    assign xfer     = ovalid_p0 && bus.oready;
    assign ready    = !irst && !pend_vld && free;
    assign accept   = bus.ivalid && ready;
    assign stray    = accept && !bus.isop && !in_pkt;
    assign restart  = accept && bus.isop && in_pkt;
    // An eop word with 1..4 valid bytes fits entirely in the high half.
    assign single   = bus.ieop && (bus.iresidual != 3'd0) && (bus.iresidual <= 3'd4);
    assign hi_bytes = single ? bus.iresidual : 3'd4;
    // Residual 0 wraps to 4 here, which is exactly the full low half.
    assign lo_bytes = bus.ieop ? (bus.iresidual - 3'd4) : 3'd4;
    assign hi_count = sat_add(bus.isop ? 14'd0 : count, hi_bytes);
    assign lo_count = sat_add(count, pend_bytes);

    // Output beat register, pending flag, framing and byte count
    always_ff @(posedge iclk) begin
        if (irst) begin
            ovalid_p0 <= 1'b0;
            osop_p0   <= 1'b0;
            oeop_p0   <= 1'b0;
            odata_p0  <= '0;
            ores_p0   <= '0;
            obad_p0   <= 1'b0;
            oplen_p0  <= '0;
            irq_p0    <= 1'b0;
            pend_vld  <= 1'b0;
            in_pkt    <= 1'b0;
            count     <= '0;
        end else begin
            irq_p0 <= (xfer && oeop_p0 && obad_p0) || stray || restart;
            if (accept && !stray) begin
                in_pkt    <= !bus.ieop;
                ovalid_p0 <= 1'b1;
                osop_p0   <= bus.isop;
                oeop_p0   <= single;
                odata_p0  <= bus.idata[63:32];
                ores_p0   <= single ? bus.iresidual[1:0] : 2'd0;
                oplen_p0  <= single ? hi_count : 14'd0;
                obad_p0   <= single && (bus.ibad || len_bad(hi_count));
                count     <= hi_count;
                pend_vld  <= !single;
            end else if (free) begin
                if (pend_vld) begin
                    ovalid_p0 <= 1'b1;
                    osop_p0   <= 1'b0;
                    oeop_p0   <= pend_eop;
                    odata_p0  <= pend_data;
                    ores_p0   <= pend_eop ? pend_bytes[1:0] : 2'd0;
                    oplen_p0  <= pend_eop ? lo_count : 14'd0;
                    obad_p0   <= pend_eop && (pend_bad || len_bad(lo_count));
                    count     <= lo_count;
                    pend_vld  <= 1'b0;
                end else begin
                    ovalid_p0 <= 1'b0;
                    osop_p0   <= 1'b0;
                    oeop_p0   <= 1'b0;
                    odata_p0  <= '0;
                    ores_p0   <= '0;
                    obad_p0   <= 1'b0;
                    oplen_p0  <= '0;
                end
            end
        end
    end

    // Low-half payload; only meaningful while pend_vld is set
    always_ff @(posedge iclk) begin
        if (accept) begin
            pend_data  <= bus.idata[31:0];
            pend_eop   <= bus.ieop;
            pend_bytes <= lo_bytes;
            pend_bad   <= bus.ibad;
        end
    end

    assign bus.iready         = ready;
    assign bus.ovalid         = ovalid_p0;
    assign bus.osop           = osop_p0;
    assign bus.oeop           = oeop_p0;
    assign bus.odata          = odata_p0;
    assign bus.oresidual      = ores_p0;
    assign bus.obad           = obad_p0;
    assign bus.oplen          = oplen_p0;
    assign bus.ocpu_interrupt = irq_p0;

endmodule

// File: tb/tb_packet_serializer.sv
// Randomized bench for packet_serializer: a byte-level packet model predicts every
// beat and every interrupt cycle.
`timescale 1ns/1ps
module tb_packet_serializer;

    localparam int MAX_PLEN = 9216;
    localparam int MIN_PLEN = 64;

    logic iclk = 1'b0;
    logic irst;
    always #5 iclk = ~iclk;

    packet_serializer_if bus();

    packet_serializer #(.MAX_PLEN(MAX_PLEN), .MIN_PLEN(MIN_PLEN)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  r;
        logic        b;
        logic [13:0] l;
    } beat_t;

    beat_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    xfer_n = 0;
    int    consec_n = 0;
    int    irq_n = 0;
    bit    rnd_ready = 0;
    logic  ready_val = 1'b1;

    int    m_len = 0;
    bit    m_in = 0;
    bit    int_exp = 0;
    bit    prev_x = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge iclk) begin
        #1;
        bus.oready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Reference model and output monitor
    always @(negedge iclk) begin
        bit    bx;
        bit    ferr;
        beat_t ob;
        if (bus.ocpu_interrupt) irq_n++;
        chk("irq", bus.ocpu_interrupt, int_exp);
        if (irst) begin
            q.delete();
            m_in = 0;
            m_len = 0;
            int_exp = 0;
            prev_x = 0;
        end else begin
            bx = 0;
            ferr = 0;
            if (bus.ovalid) begin
                if (q.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    ob = {bus.odata, bus.osop, bus.oeop, bus.oresidual, bus.obad & bus.oeop, bus.oplen};
                    chk("beat", ob, q[0]);
                    if (bus.oready) begin
                        bx = q[0].e && q[0].b;
                        void'(q.pop_front());
                        xfer_n++;
                        if (prev_x) consec_n++;
                    end
                end
            end
            prev_x = bus.ovalid && bus.oready;
            if (bus.ivalid && bus.iready) begin
                if (!bus.isop && !m_in) ferr = 1;
                else begin
                    int nb;
                    int nbeats;
                    if (bus.isop && m_in) ferr = 1;
                    if (bus.isop) m_len = 0;
                    m_in = !bus.ieop;
                    nb = bus.ieop ? ((bus.iresidual == 0) ? 8 : int'(bus.iresidual)) : 8;
                    nbeats = (nb + 3) / 4;
                    for (int k = 0; k < nbeats; k++) begin
                        beat_t nbt;
                        int bb;
                        bb = (nb - 4 * k > 4) ? 4 : nb - 4 * k;
                        m_len = (m_len + bb > 16383) ? 16383 : m_len + bb;
                        nbt.d = (k == 0) ? bus.idata[63:32] : bus.idata[31:0];
                        nbt.s = bus.isop && (k == 0);
                        nbt.e = bus.ieop && (k == nbeats - 1);
                        nbt.r = nbt.e ? 2'(bb % 4) : 2'd0;
                        nbt.l = nbt.e ? 14'(m_len) : 14'd0;
                        nbt.b = nbt.e && (bus.ibad || m_len > MAX_PLEN || m_len < MIN_PLEN);
                        q.push_back(nbt);
                    end
                end
            end
            int_exp = bx || ferr;
        end
    end

    task automatic send_word(input bit s, input bit e, input logic [2:0] r, input bit b,
                             input logic [63:0] d);
        int waits;
        bit acc;
        waits = 0;
        acc = 0;
        bus.ivalid = 1'b1;
        bus.isop = s;
        bus.ieop = e;
        bus.iresidual = r;
        bus.ibad = b;
        bus.idata = d;
        while (!acc) begin
            @(negedge iclk);
            acc = bus.iready;
            @(posedge iclk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 5000) begin
                    chk("iready_timeout", 0, 1);
                    break;
                end
            end
        end
    endtask

    task automatic idle();
        bus.ivalid = 1'b0;
        bus.isop = 1'b0;
        bus.ieop = 1'b0;
    endtask

    task automatic send_pkt(input int nbytes, input bit bad);
        int nw;
        nw = (nbytes + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            bit e;
            e = (i == nw - 1);
            send_word(i == 0, e, e ? 3'(nbytes % 8) : 3'd0, e ? bad : 1'($urandom_range(0, 1)),
                      {$urandom, $urandom});
        end
        idle();
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || bus.ovalid) && w < 30000) begin
            @(posedge iclk);
            w++;
        end
        repeat (3) @(posedge iclk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n0;
        int c0;
        int i0;
        irst = 1'b1;
        bus.ivalid = 1'b0;
        bus.isop = 1'b0;
        bus.ieop = 1'b0;
        bus.idata = '0;
        bus.iresidual = '0;
        bus.ibad = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_outputs", {bus.ovalid, bus.osop, bus.oeop, bus.odata, bus.oresidual,
                            bus.obad, bus.oplen, bus.ocpu_interrupt}, 0);
        chk("rst_iready", bus.iready, 0);
        irst = 1'b0;
        #1;
        chk("iready_post_rst", bus.iready, 1);
        @(posedge iclk);
        #1;

        n0 = xfer_n; c0 = consec_n; i0 = irq_n;
        send_pkt(64, 0);
        drain();
        chk("t64_beats", xfer_n - n0, 16);
        chk("t64_b2b", consec_n - c0, 15);
        chk("t64_irq", irq_n - i0, 0);

        n0 = xfer_n;
        send_pkt(66, 0);
        send_pkt(71, 0);
        drain();
        chk("t66_71_beats", xfer_n - n0, 35);

        rnd_ready = 1;
        i0 = irq_n;
        send_pkt(9216, 0);
        drain();
        chk("t9216_irq", irq_n - i0, 0);

        i0 = irq_n;
        send_pkt(9220, 0);
        drain();
        chk("t9220_irq", irq_n - i0, 1);
        i0 = irq_n;
        send_pkt(60, 0);
        drain();
        chk("t60_irq", irq_n - i0, 1);

        n0 = xfer_n; i0 = irq_n;
        send_word(0, 0, 3'd0, 0, {$urandom, $urandom});
        idle();
        drain();
        chk("stray_beats", xfer_n - n0, 0);
        chk("stray_irq", irq_n - i0, 1);

        i0 = irq_n;
        send_word(1, 0, 3'd0, 0, {$urandom, $urandom});
        send_word(0, 0, 3'd0, 0, {$urandom, $urandom});
        send_pkt(64, 0);
        drain();
        chk("restart_irq", irq_n - i0, 1);

        rnd_ready = 0;
        ready_val = 1'b0;
        @(posedge iclk);
        #1;
        send_word(1, 0, 3'd0, 0, {$urandom, $urandom});
        idle();
        chk("pend_state", {bus.ovalid, bus.iready}, 2'b10);
        irst = 1'b1;
        @(negedge iclk);
        chk("iready_in_rst", bus.iready, 0);
        @(posedge iclk);
        #1;
        irst = 1'b0;
        #1;
        chk("midrst_outputs", {bus.ovalid, bus.osop, bus.oeop, bus.odata, bus.oresidual,
                               bus.obad, bus.oplen, bus.ocpu_interrupt}, 0);
        chk("midrst_iready", bus.iready, 1);
        ready_val = 1'b1;
        @(posedge iclk);
        #1;
        send_pkt(80, 0);
        drain();

        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                send_word(0, 1'($urandom_range(0, 1)), 3'($urandom), 0, {$urandom, $urandom});
            send_pkt($urandom_range(1, 150), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge iclk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
